l2r_exp_datapath: RTL and testbench
===================================

// Module: l2r_exp_datapath
// PURPOSE
//  Datapath for the left-to-right binary exponentiation unit: computes A_in^B_in mod 2^DATA_W.
//  Sits directly downstream of the exponentiation control unit. It consumes that unit's control
//  word (LoadA..S_C, Done) and returns the status bits `equals` and `regBk`.
//  Holds the base, exponent shift, accumulator and iteration-counter registers.
//  Captures the final result and a sticky overflow flag when Done pulses.
// PARAMETERS
//  DATA_W  8  width of base A, accumulator C and Result
//  EXP_W   8  width of exponent B; number of square/multiply iterations
//  localparam CNT_W = $clog2(EXP_W+2)  counter width; must hold EXP_W+1 without wrap
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  A_in       in   DATA_W   base operand, sampled on LoadA
//  B_in       in   EXP_W    exponent operand, sampled on LoadB
//  LoadA      in   1        A <= A_in
//  LoadCoun   in   1        counter update enable
//  LoadB      in   1        B <= B_in
//  ShiftB     in   1        B <= B << 1 (zero fill)
//  LoadC      in   1        accumulator update enable
//  S_Coun     in   1        counter source: 0 -> clear to 0, 1 -> increment
//  S_C        in   2        C source: 00 -> 1, 01 -> C*C, 10 -> C*A, 11 -> hold
//  Done       in   1        one-cycle end-of-operation pulse from control unit
//  equals     out  1        combinational: Coun == EXP_W
//  regBk      out  1        combinational: B[EXP_W-1] (current exponent MSB)
//  Result     out  DATA_W   captured C, stable until next capture
//  ResValid   out  1        Result valid
//  Ovf        out  1        captured sticky overflow for Result
// BEHAVIOUR
//  - Reset (rst_n=0, async): A=0, B=0, C=1, Coun=0, OvfAcc=0, Result=0, ResValid=0, Ovf=0.
//    Therefore equals=0 and regBk=0 during reset.
//  - All register updates occur on posedge clk. Each control input acts in the cycle it is high.
//  - A: loads on LoadA; otherwise holds.
//  - B: LoadB has priority over ShiftB when both are high. With neither high, B holds.
//  - Coun: on LoadCoun, S_Coun=0 gives 0 and S_Coun=1 gives Coun+1.
//    Coun saturates at 2^CNT_W-1 (never wraps). Without LoadCoun it holds.
//  - C: updates only when LoadC=1, selected by S_C.
//    Products are full 2*DATA_W wide combinational multiplies; the low DATA_W bits are stored.
//    S_C=11 with LoadC holds C.
//  - OvfAcc, internal sticky flag:
//    - set when LoadC and S_C in {01,10} and product[2*DATA_W-1:DATA_W] != 0;
//    - cleared when LoadA=1 (new operation start);
//    - set has priority over clear when both occur in the same cycle.
//  - Result capture: on a clock edge with Done=1, Result <= C (value before this edge),
//    Ovf <= OvfAcc, ResValid <= 1.
//    The control unit issues no C update in the Done cycle, so the captured C is final.
//  - ResValid clears on LoadA (new operation). If Done and LoadA coincide, Done wins.
//  - Algorithm contract with control unit:
//    - start: LoadA, LoadB, LoadCoun with S_Coun=0, LoadC with S_C=00;
//    - loop while !equals: square C and increment Coun; if regBk, multiply C by A;
//    - shift B after the regBk decision;
//    - EXP_W iterations yield A^B mod 2^DATA_W.
//  - Edge cases: 0^0=1 and x^0=1 (C stays 1); 0^k=0 for k>0.
//    Idle LoadC S_C=00 every cycle keeps C=1 and does not disturb Result/ResValid/Ovf.
//  - Reset mid-operation: all state returns to reset values immediately; no partial Result is kept.
// TESTING
//  - Reset: assert rst_n=0 mid-loop -> C=1, Coun=0, ResValid=0, Ovf=0, equals=0 asynchronously.
//  - Paired with control unit, A_in=3, B_in=5 -> Done pulse; Result=243, Ovf=0, ResValid=1.
//  - A_in=3, B_in=6 -> Result=217 (729 mod 256), Ovf=1; next start (LoadA) clears ResValid and OvfAcc.
//  - A_in=0, B_in=0 -> Result=1. A_in=7, B_in=0 -> Result=1. A_in=0, B_in=3 -> Result=0, Ovf=0.
//  - Direct drive: B=8'h80, LoadB=1 & ShiftB=1 with B_in=8'h01 -> B=01, regBk=0. ShiftB alone from 80 -> 00.
//  - Direct drive: LoadCoun with S_Coun=1 for 20 cycles from 0 -> Coun saturates at 15, equals high only at 8.

Source files
------------

// File: rtl/l2r_exp_datapath.sv
// l2r_exp_datapath
// Register-level datapath for left-to-right binary exponentiation.
// Computes A^B mod 2^DATA_W under the direction of an external control unit,
// reporting back the loop-termination (equals) and exponent-MSB (regBk) status.
module l2r_exp_datapath #(
  parameter int DATA_W = 8,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A_in,
  input  logic [EXP_W-1:0]  B_in,
  input  logic              LoadA,
  input  logic              LoadCoun,
  input  logic              LoadB,
  input  logic              ShiftB,
  input  logic              LoadC,
  input  logic              S_Coun,
  input  logic [1:0]        S_C,
  input  logic              Done,
  output logic              equals,
  output logic              regBk,
  output logic [DATA_W-1:0] Result,
  output logic              ResValid,
  output logic              Ovf
);

  // Counter must reach EXP_W+1 without wrapping so saturation never aliases to EXP_W.
  localparam int CNT_W = $clog2(EXP_W + 2);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LP_CNT_EXP = CNT_W'(EXP_W);
  localparam logic [DATA_W-1:0] LP_ONE = DATA_W'(1);

  logic [DATA_W-1:0]   r_a;
  logic [EXP_W-1:0]    r_b;
  logic [DATA_W-1:0]   r_c;
  logic [CNT_W-1:0]    r_coun;
  logic                r_ovfAcc;
  logic [DATA_W-1:0]   r_result;
  logic                r_resValid;
  logic                r_ovf;

  logic [2*DATA_W-1:0] w_prodSq;
  logic [2*DATA_W-1:0] w_prodMul;
  logic                w_ovfSet;

  // Full-width products; the upper half only feeds overflow detection.
  assign w_prodSq  = {{DATA_W{1'b0}}, r_c} * {{DATA_W{1'b0}}, r_c};
  assign w_prodMul = {{DATA_W{1'b0}}, r_c} * {{DATA_W{1'b0}}, r_a};

  assign w_ovfSet = LoadC &&
                    (((S_C == 2'b01) && (|w_prodSq[2*DATA_W-1:DATA_W])) ||
                     ((S_C == 2'b10) && (|w_prodMul[2*DATA_W-1:DATA_W])));

  assign equals   = (r_coun == LP_CNT_EXP);
  assign regBk    = r_b[EXP_W-1];
  assign Result   = r_result;
  assign ResValid = r_resValid;
  assign Ovf      = r_ovf;

  // Base register: captured once at the start of an operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_a <= '0;
    else if (LoadA) r_a <= A_in;
  end

  // Exponent register: a fresh load overrides a shift in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_b <= '0;
    else if (LoadB)  r_b <= B_in;
    else if (ShiftB) r_b <= {r_b[EXP_W-2:0], 1'b0};
  end

  // Iteration counter: clear or saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coun <= '0;
    end else if (LoadCoun) begin
      if (!S_Coun)                   r_coun <= '0;
      else if (r_coun != LP_CNT_MAX) r_coun <= r_coun + 1'b1;
    end
  end

  // Accumulator: reinitialise to 1, square, multiply by base, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c <= LP_ONE;
    end else if (LoadC) begin
      case (S_C)
        2'b00:   r_c <= LP_ONE;
        2'b01:   r_c <= w_prodSq[DATA_W-1:0];
        2'b10:   r_c <= w_prodMul[DATA_W-1:0];
        default: r_c <= r_c;
      endcase
    end
  end

  // Sticky overflow: any truncated product taints the operation; a set in the start cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ovfAcc <= 1'b0;
    else if (w_ovfSet) r_ovfAcc <= 1'b1;
    else if (LoadA)    r_ovfAcc <= 1'b0;
  end

  // Result capture on Done; a new start only invalidates, the old value stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_resValid <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (Done) begin
      r_result   <= r_c;
      r_resValid <= 1'b1;
      r_ovf      <= r_ovfAcc;
    end else if (LoadA) begin
      r_resValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l2r_exp_datapath.sv
// tb_l2r_exp_datapath
// Directed bench: plays the control unit's role for whole exponentiations and
// drives individual control bits directly for the B register and counter.
module tb_l2r_exp_datapath;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] A_in;
  logic [7:0] B_in;
  logic       LoadA, LoadCoun, LoadB, ShiftB, LoadC, S_Coun, Done;
  logic [1:0] S_C;
  logic       equals, regBk, ResValid, Ovf;
  logic [7:0] Result;

  int errors = 0;
  int checks = 0;

  l2r_exp_datapath #(.DATA_W(8), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .A_in(A_in), .B_in(B_in),
    .LoadA(LoadA), .LoadCoun(LoadCoun), .LoadB(LoadB), .ShiftB(ShiftB),
    .LoadC(LoadC), .S_Coun(S_Coun), .S_C(S_C), .Done(Done),
    .equals(equals), .regBk(regBk), .Result(Result),
    .ResValid(ResValid), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle's control word, clock it in, and settle just after the edge.
  task automatic applyStimulus(input logic la, input logic lb, input logic sb,
                               input logic lcn, input logic scn, input logic lc,
                               input logic [1:0] sc, input logic dn);
    LoadA = la; LoadB = lb; ShiftB = sb; LoadCoun = lcn; S_Coun = scn;
    LoadC = lc; S_C = sc; Done = dn;
    @(posedge clk);
    #1;
  endtask

  // Start an operation the way the control unit does.
  task automatic startExp(input logic [7:0] a, input logic [7:0] b, input string tag);
    A_in = a; B_in = b;
    applyStimulus(1, 1, 0, 1, 0, 1, 2'b00, 0);
    checkOutput({tag, "_validCleared"}, ResValid, 0);
    checkOutput({tag, "_ovfAccCleared"}, dut.r_ovfAcc, 0);
  endtask

  // Full operation: start, square/multiply loop bounded by a budget, Done, check.
  task automatic runExp(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] expRes, input logic expOvf, input string tag);
    int   iter;
    logic bitK;
    startExp(a, b, tag);
    iter = 0;
    while (!equals && iter < 20) begin
      bitK = regBk;
      applyStimulus(0, 0, 1, 1, 1, 1, 2'b01, 0);
      if (bitK) applyStimulus(0, 0, 0, 0, 0, 1, 2'b10, 0);
      iter++;
    end
    checkOutput({tag, "_iterations"}, iter, 8);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b11, 1);
    checkOutput({tag, "_result"}, Result, expRes);
    checkOutput({tag, "_ovf"}, Ovf, expOvf);
    checkOutput({tag, "_valid"}, ResValid, 1);
  endtask

  initial begin
    int expCnt;
    rst_n = 1'b0;
    A_in = '0; B_in = '0;
    LoadA = 0; LoadB = 0; ShiftB = 0; LoadCoun = 0; S_Coun = 0;
    LoadC = 0; S_C = 2'b00; Done = 0;
    #12;
    checkOutput("reset_result", Result, 0);
    checkOutput("reset_valid", ResValid, 0);
    checkOutput("reset_ovf", Ovf, 0);
    checkOutput("reset_equals", equals, 0);
    checkOutput("reset_regBk", regBk, 0);
    checkOutput("reset_c", dut.r_c, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Exponentiations, overflow first so the following start must clear it.
    runExp(8'd3, 8'd6, 8'd217, 1'b1, "exp3_6");
    runExp(8'd3, 8'd5, 8'd243, 1'b0, "exp3_5");

    // Idle reinitialisation of C leaves the captured result untouched.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 2'b00, 0);
    checkOutput("idle_result", Result, 243);
    checkOutput("idle_valid", ResValid, 1);
    checkOutput("idle_c", dut.r_c, 1);

    runExp(8'd0, 8'd0, 8'd1, 1'b0, "exp0_0");
    runExp(8'd7, 8'd0, 8'd1, 1'b0, "exp7_0");
    runExp(8'd0, 8'd3, 8'd0, 1'b0, "exp0_3");
    runExp(8'd3, 8'd6, 8'd217, 1'b1, "exp3_6b");

    // Reset in the middle of a loop wipes everything asynchronously.
    startExp(8'd3, 8'd6, "midrst");
    applyStimulus(0, 0, 1, 1, 1, 1, 2'b01, 0);
    applyStimulus(0, 0, 1, 1, 1, 1, 2'b01, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_c", dut.r_c, 1);
    checkOutput("midrst_coun", dut.r_coun, 0);
    checkOutput("midrst_result", Result, 0);
    checkOutput("midrst_valid", ResValid, 0);
    checkOutput("midrst_ovf", Ovf, 0);
    checkOutput("midrst_equals", equals, 0);
    LoadA = 0; LoadB = 0; ShiftB = 0; LoadCoun = 0; S_Coun = 0;
    LoadC = 0; S_C = 2'b00; Done = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // B register: load beats shift, plain shift zero-fills.
    B_in = 8'h80;
    applyStimulus(0, 1, 0, 0, 0, 0, 2'b11, 0);
    checkOutput("b_load80_regBk", regBk, 1);
    B_in = 8'h01;
    applyStimulus(0, 1, 1, 0, 0, 0, 2'b11, 0);
    checkOutput("b_loadWins_b", dut.r_b, 8'h01);
    checkOutput("b_loadWins_regBk", regBk, 0);
    B_in = 8'h80;
    applyStimulus(0, 1, 0, 0, 0, 0, 2'b11, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 2'b11, 0);
    checkOutput("b_shift_b", dut.r_b, 8'h00);
    checkOutput("b_shift_regBk", regBk, 0);

    // Counter: clear, then 20 increments saturating at 15; equals only at 8.
    applyStimulus(0, 0, 0, 1, 0, 0, 2'b11, 0);
    checkOutput("cnt_clear", dut.r_coun, 0);
    checkOutput("cnt_clear_equals", equals, 0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 0, 2'b11, 0);
      expCnt = (i > 15) ? 15 : i;
      checkOutput($sformatf("cnt_%0d", i), dut.r_coun, expCnt);
      checkOutput($sformatf("cnt_equals_%0d", i), equals, (expCnt == 8) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 2'b11, 0);
    checkOutput("cnt_hold", dut.r_coun, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
